div_seq_ctrl: RTL and testbench

//   Iterative restoring divider: unsigned WIDTH-bit dividend / divisor, one quotient bit per cycle.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_sub_row.sv | 31 +++
 rtl/div_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_div_seq_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_WIDTH_DEF = 4;

    // Bits needed to hold an iteration count of 0..width.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_sub_row.sv
// One row of WIDTH+1 ripple borrow subtract cells with a restore select:
// y = restore ? a : (a - b); borrow is the final borrow out of the MSB cell.
module div_sub_row
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           restore,
    output logic [WIDTH:0] y,
    output logic           borrow
);

    logic [WIDTH:0] w_diff;
    logic           w_bw;

    // Ripple the borrow from LSB to MSB, one full-subtractor cell per bit.
    always_comb begin
        w_diff = {(WIDTH + 1){1'b0}};
        w_bw   = 1'b0;
        for (int i = 0; i <= WIDTH; i++) begin
            w_diff[i] = a[i] ^ b[i] ^ w_bw;
            w_bw      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_bw);
        end
    end

    assign borrow = w_bw;
    assign y      = restore ? a : w_diff;

endmodule

// File: rtl/div_seq_ctrl.sv
// Iterative restoring divider controller: one quotient bit per BUSY cycle.
// Optional DIV_ZERO_CHK_EN short-circuits a zero divisor straight to DONE.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int             CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH:0]   r_r;
    logic [CW-1:0]    r_cnt;
    logic             r_dz;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_retire;
    logic             w_div0;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_row_y;
    logic             w_borrow;
    logic             w_unused;

    assign w_accept  = in_valid & r_in_ready;
    assign w_retire  = r_out_valid & out_ready;
    assign w_shifted = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
    // R's MSB is only ever a transient of the trial subtract; it is always 0 once stored.
    assign w_unused  = r_r[WIDTH];

`ifdef DIV_ZERO_CHK_EN
    assign w_div0 = (divisor == {WIDTH{1'b0}});
`else
    assign w_div0 = 1'b0;
`endif

    div_sub_row #(
        .WIDTH   (WIDTH)
    ) u_row (
        .a       (w_shifted),
        .b       ({1'b0, r_d}),
        .restore (w_borrow),
        .y       (w_row_y),
        .borrow  (w_borrow)
    );

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_div0 ? DONE : BUSY;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = BUSY;
                end
            end
            DONE: begin
                if (w_retire) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, handshake flags and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_q         <= {WIDTH{1'b0}};
            r_d         <= {WIDTH{1'b0}};
            r_r         <= {(WIDTH + 1){1'b0}};
            r_cnt       <= {CW{1'b0}};
            r_dz        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            if (w_accept) begin
                r_d   <= divisor;
                r_cnt <= {CW{1'b0}};
                r_dz  <= w_div0;
                if (w_div0) begin
                    r_q <= {WIDTH{1'b1}};
                    r_r <= {1'b0, dividend};
                end else begin
                    r_q <= dividend;
                    r_r <= {(WIDTH + 1){1'b0}};
                end
            end else if (r_state == BUSY) begin
                r_r   <= w_row_y;
                r_q   <= {r_q[WIDTH-2:0], ~w_borrow};
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign quotient  = r_q;
    assign remainder = r_r[WIDTH-1:0];
    assign div_zero  = r_dz;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: timestamp/arithmetic model checked every cycle,
// plus directed jobs with hand-computed results.
module tb_div_seq_ctrl;

    localparam int W    = 4;
    localparam int ONES = (1 << W) - 1;
`ifdef DIV_ZERO_CHK_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    int n_tests = 0;
    int n_fail  = 0;

    div_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a job is accepted at some edge; its result is due a fixed number of edges later.
    bit      m_job = 1'b0;
    longint  m_ecnt = 0;
    longint  m_ready_at = 0;
    int      m_q, m_r, m_dz;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_job = 1'b0;
        end else if (m_job) begin
            if (m_ecnt >= m_ready_at && out_ready) m_job = 1'b0;
        end else if (in_valid) begin
            m_job = 1'b1;
            if (divisor == 0) begin
                m_q = ONES;
                m_r = int'(dividend);
                m_dz = DZ_EN ? 1 : 0;
                m_ready_at = m_ecnt + 1 + (DZ_EN ? 0 : W);
            end else begin
                m_q = int'(dividend) / int'(divisor);
                m_r = int'(dividend) % int'(divisor);
                m_dz = 0;
                m_ready_at = m_ecnt + 1 + W;
            end
        end
        m_ecnt++;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_quotient", quotient, 0);
            chk("rst_remainder", remainder, 0);
            chk("rst_div_zero", div_zero, 0);
        end else begin
            chk("in_ready", in_ready, !m_job);
            chk("out_valid", out_valid, (m_job && m_ecnt >= m_ready_at));
            if (m_job && m_ecnt >= m_ready_at) begin
                chk("quotient", quotient, m_q);
                chk("remainder", remainder, m_r);
                chk("div_zero", div_zero, m_dz);
            end
        end
    end

    task automatic run_job(input int a, input int b, input int eq, input int er,
                           input int edz, input int elat, input int stall);
        int lat;
        bit seen;
        chk("idle_before_job", in_ready, 1);
        dividend = W'(a);
        divisor  = W'(b);
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        lat = 0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", seen ? lat : -1, elat);
        chk("job_quotient", quotient, eq);
        chk("job_remainder", remainder, er);
        chk("job_div_zero", div_zero, edz);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            dividend = W'(1);
            divisor  = W'(1);
            @(posedge clk); #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_quotient", quotient, eq);
            chk("stall_remainder", remainder, er);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("retire_in_ready", in_ready, 1);
        chk("retire_out_valid", out_valid, 0);
    endtask

    initial begin
        bit acc;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_job(13, 4, 3, 1, 0, W, 0);
        run_job(15, 1, 15, 0, 0, W, 0);
        run_job(5, 7, 0, 5, 0, W, 0);
        run_job(0, 3, 0, 0, 0, W, 0);
        if (DZ_EN) run_job(9, 0, 15, 9, 1, 0, 0);
        else       run_job(9, 0, 15, 9, 0, W, 0);
        run_job(14, 3, 4, 2, 0, W, 3);

        // Reset in the middle of a job.
        dividend = W'(11);
        divisor  = W'(2);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_quotient", quotient, 0);
        chk("midrst_remainder", remainder, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_job(11, 2, 5, 1, 0, W, 0);

        // All dividend/divisor pairs with random consumer stalls; the model checks each cycle.
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                dividend = W'(a);
                divisor  = W'(b);
                in_valid = 1'b1;
                acc = 1'b0;
                for (int k = 0; k < 80 && !acc; k++) begin
                    @(negedge clk);
                    acc = in_ready;
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                in_valid = 1'b0;
                if (!acc) chk("accept_timeout", 0, 1);
            end
        end
        out_ready = 1'b1;
        repeat (W + 3) begin
            @(posedge clk); #1;
        end
        chk("drain_in_ready", in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
